// File: rtl/fib_chk_pkg.sv
// Shared types for the Fibonacci pair checker: FSM state codes and the state enum.
package fib_chk_pkg;

  localparam logic [1:0] IDLE_CODE  = 2'd0;
  localparam logic [1:0] ARM_CODE   = 2'd1;
  localparam logic [1:0] CHECK_CODE = 2'd2;
  localparam logic [1:0] STOP_CODE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE_CODE,
    ST_ARM   = ARM_CODE,
    ST_CHECK = CHECK_CODE,
    ST_STOP  = STOP_CODE
  } state_e;

endpackage

// File: rtl/fib_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and a synchronous clear.
module fib_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: reset is sampled on the clock edge only, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fib_pair_checker.sv
// Checks that an upstream Fibonacci stage advances its (x, y) pair correctly.
// Define FIB_CHK_WRAP_EN to keep checking after a sum overflow instead of stopping.
module fib_pair_checker
  import fib_chk_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             selector,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] step_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err,
  output logic             ovf
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             sel_q, sel_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] exp_x;
  logic [WIDTH-1:0] exp_y;
  logic             mismatch;
  logic             ovf_hit;
  logic             do_compare;
  logic             step_inc;
  logic             err_inc;

  // The carry out of the pair sum is the overflow; the low WIDTH bits are the expected y.
  assign sum_full = {1'b0, x_q} + {1'b0, y_q};
  assign exp_x    = sel_q ? y_q : x_q;
  assign exp_y    = sel_q ? sum_full[WIDTH-1:0] : y_q;
  assign mismatch = (x != exp_x) || (y != exp_y);

  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    sel_d      = sel_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    ovf_hit    = 1'b0;
    do_compare = 1'b0;
    step_inc   = 1'b0;
    err_inc    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_ARM;
      end
      ST_ARM: begin
        x_d     = x;
        y_d     = y;
        sel_d   = selector;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!en) begin
          state_d = ST_ARM;
        end else begin
          ovf_hit = sel_q && sum_full[WIDTH];
          if (ovf_hit) ovf_d = 1'b1;
`ifdef FIB_CHK_WRAP_EN
          do_compare = 1'b1;
`else
          // An overflowing step is abandoned outright: no compare, no count, no recapture.
          if (ovf_hit) begin
            state_d = ST_STOP;
          end else begin
            do_compare = 1'b1;
          end
`endif
          if (do_compare) begin
            // Recapture unconditionally so a single bad sample is charged exactly once.
            x_d      = x;
            y_d      = y;
            sel_d    = selector;
            step_inc = sel_q;
            if (mismatch) begin
              err_d   = 1'b1;
              err_inc = 1'b1;
            end
          end
        end
      end
      ST_STOP: begin
        state_d = ST_STOP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  fib_sat_counter #(.CNT_W(CNT_W)) u_step_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (step_inc),
    .clear (1'b0),
    .count (step_cnt)
  );

  fib_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clear (1'b0),
    .count (err_cnt)
  );

  assign state_o = state_q;
  assign err     = err_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_fib_pair_checker.sv
// Scoreboard bench for fib_pair_checker: directed scenarios plus random traffic against a behavioural model.
module tb_fib_pair_checker;

  localparam int WIDTH = 11;
  localparam int CNT_W = 4;
  localparam int MOD   = 1 << WIDTH;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             en;
  logic             selector;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err;
  logic             ovf;

  fib_pair_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .selector (selector),
    .x        (x),
    .y        (y),
    .state_o  (state_o),
    .step_cnt (step_cnt),
    .err_cnt  (err_cnt),
    .err      (err),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int step;
    int errc;
    int err;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model of the checker: mode 0 idle, 1 arm, 2 check, 3 stop.
  int m_st, m_x, m_y, m_sel, m_step, m_errc, m_err, m_ovf;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit e, input bit s, input int xv, input int yv);
    int  sum, ex, ey;
    bit  carry;
    if (!r) begin
      m_st = 0; m_x = 0; m_y = 0; m_sel = 0;
      m_step = 0; m_errc = 0; m_err = 0; m_ovf = 0;
      return;
    end
    case (m_st)
      0: if (e) m_st = 1;
      1: begin
        m_x = xv; m_y = yv; m_sel = s; m_st = 2;
      end
      2: begin
        if (!e) begin
          m_st = 1;
        end else begin
          sum   = m_x + m_y;
          carry = (m_sel != 0) && (sum >= MOD);
          if (carry) m_ovf = 1;
`ifndef FIB_CHK_WRAP_EN
          if (carry) begin
            m_st = 3;
            return;
          end
`endif
          ex = (m_sel != 0) ? m_y : m_x;
          ey = (m_sel != 0) ? (sum % MOD) : m_y;
          if (xv != ex || yv != ey) begin
            m_err = 1;
            if (m_errc < CMAX) m_errc++;
          end
          if (m_sel != 0 && m_step < CMAX) m_step++;
          m_x = xv; m_y = yv; m_sel = s;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic apply(input bit r, input bit e, input bit s, input int xv, input int yv);
    int xm, ym;
    xm = xv % MOD;
    ym = yv % MOD;
    @(negedge clk);
    rst      = r;
    en       = e;
    selector = s;
    x        = WIDTH'(xm);
    y        = WIDTH'(ym);
    model_step(r, e, s, xm, ym);
    exp_q.push_back('{m_st, m_step, m_errc, m_err, m_ovf});
  endtask

  // Lands just after the edge that consumed the last applied input, before the next drive.
  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are meaningful every cycle, so one expectation is consumed per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_state", int'(state_o), e.st);
        check("sb_step_cnt", int'(step_cnt), e.step);
        check("sb_err_cnt", int'(err_cnt), e.errc);
        check("sb_err", int'(err), e.err);
        check("sb_ovf", int'(ovf), e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int xv, yv;
    bit r, e, s;
    rst = 1'b0; en = 1'b0; selector = 1'b0; x = '0; y = '0;

    // Clean Fibonacci advance.
    apply(0, 0, 0, 0, 0);
    apply(0, 1, 1, 0, 0);
    after_edge();
    check("rst_state", int'(state_o), 0);
    check("rst_counts", int'(step_cnt) + int'(err_cnt), 0);
    apply(1, 1, 1, 1, 1);
    apply(1, 1, 1, 1, 1);
    apply(1, 1, 1, 1, 2);
    apply(1, 1, 1, 2, 3);
    apply(1, 1, 1, 3, 5);
    after_edge();
    check("adv_step_cnt", int'(step_cnt), 3);
    check("adv_err", int'(err), 0);
    check("adv_err_cnt", int'(err_cnt), 0);

    // Hold pair with selector low: no steps counted.
    apply(0, 0, 0, 0, 0);
    apply(1, 1, 0, 5, 8);
    apply(1, 1, 0, 5, 8);
    for (int i = 0; i < 4; i++) apply(1, 1, 0, 5, 8);
    after_edge();
    check("hold_step_cnt", int'(step_cnt), 0);
    check("hold_err", int'(err), 0);
    check("hold_state", int'(state_o), 2);

    // Single fault counted once.
    apply(0, 0, 0, 0, 0);
    apply(1, 1, 1, 2, 3);
    apply(1, 1, 1, 2, 3);
    apply(1, 1, 1, 3, 6);
    after_edge();
    check("fault_err", int'(err), 1);
    check("fault_err_cnt", int'(err_cnt), 1);
    apply(1, 1, 1, 6, 9);
    after_edge();
    check("fault_once_err_cnt", int'(err_cnt), 1);

    // Reset from CHECK with err set.
    apply(0, 1, 1, 6, 15);
    after_edge();
    check("rst_chk_state", int'(state_o), 0);
    check("rst_chk_all", int'(step_cnt) + int'(err_cnt) + int'(err) + int'(ovf), 0);

    // Overflow: 987 + 1597 = 2584 -> 536 in 11 bits.
    apply(1, 1, 1, 987, 1597);
    apply(1, 1, 1, 987, 1597);
    apply(1, 1, 1, 1597, 536);
    after_edge();
    check("ovf_flag", int'(ovf), 1);
`ifdef FIB_CHK_WRAP_EN
    check("ovf_err", int'(err), 0);
    check("ovf_state", int'(state_o), 2);
    check("ovf_step_cnt", int'(step_cnt), 1);
`else
    check("ovf_state", int'(state_o), 3);
    check("ovf_step_cnt", int'(step_cnt), 0);
    check("ovf_err", int'(err), 0);
`endif
    apply(1, 1, 1, 5, 5);
    apply(1, 0, 0, 7, 1);
    apply(1, 1, 0, 2, 9);
    after_edge();
`ifndef FIB_CHK_WRAP_EN
    check("stop_state", int'(state_o), 3);
    check("stop_frozen", int'(step_cnt) + int'(err_cnt) + int'(err), 0);
`endif
    apply(0, 1, 1, 5, 5);
    after_edge();
    check("stop_rst_state", int'(state_o), 0);
    check("stop_rst_ovf", int'(ovf), 0);

    // Error counter saturation with 17 mismatches.
    apply(1, 1, 0, 0, 0);
    apply(1, 1, 0, 0, 0);
    for (int i = 1; i <= 17; i++) apply(1, 1, 0, i, 0);
    after_edge();
    check("sat_err_cnt", int'(err_cnt), 15);
    check("sat_err", int'(err), 1);

    // Random traffic, mostly well-formed successors so long runs and overflows occur.
    apply(0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 39) != 0);
      e = ($urandom_range(0, 7) != 0);
      s = 1'($urandom_range(0, 1));
      if (m_st == 2 && $urandom_range(0, 3) != 0) begin
        xv = (m_sel != 0) ? m_y : m_x;
        yv = (m_sel != 0) ? ((m_x + m_y) % MOD) : m_y;
      end else begin
        xv = int'($urandom_range(0, MOD - 1));
        yv = int'($urandom_range(0, MOD - 1));
      end
      apply(r, e, s, xv, yv);
    end
    after_edge();
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
